// File: rtl/calc2_port_requester.sv
// calc2 request-port initiator: serializes ops into cmd/op1 + op2 beats,
// tracks four tags, matches tagged responses, flags timeouts and strays.
//
// Ports:
//   c_clk, reset        clock, synchronous active-high reset
//   op_valid/op_ready   upstream handshake; op_cmd, op_a, op_b operation
//   req_*_out           two-beat request bus towards calc2
//   out_*_in            calc2 response channel (resp, data, tag)
//   res_*               one-cycle tagged result strobe upstream
//   outstanding         busy tag count; err_timeout sticky, err_unexpected pulse
module calc2_port_requester #(
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  out_resp_in,
  input  logic [31:0] out_data_in,
  input  logic [1:0]  out_tag_in,
  output logic        res_valid,
  output logic [3:0]  res_cmd,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic [1:0]  res_tag,
  output logic [2:0]  outstanding,
  output logic        err_timeout,
  output logic        err_unexpected
);

  typedef enum logic {
    IDLE,
    SEND_B
  } state_t;

  localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  busy_q, busy_d;
  logic [3:0]  cmd_q [4];
  logic [3:0]  cmd_d [4];
  logic [7:0]  tmr_q [4];
  logic [7:0]  tmr_d [4];
  logic [31:0] b_q, b_d;
  logic [1:0]  stag_q, stag_d;

  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic [1:0]  req_tag_q, req_tag_d;

  logic        res_valid_q, res_valid_d;
  logic [3:0]  res_cmd_q, res_cmd_d;
  logic [1:0]  res_resp_q, res_resp_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_tag_q, res_tag_d;
  logic [2:0]  outst_q, outst_d;
  logic        err_to_q, err_to_d;
  logic        err_un_q, err_un_d;

  logic        have_free;
  logic [1:0]  free_tag;
  logic        alloc;
  logic        rsp_ok;
  logic        rsp_hit;
  logic        rsp_bad;
  logic [3:0]  expire;

  // lowest-numbered free tag from registered state
  always_comb begin
    free_tag  = 2'd0;
    have_free = ~&busy_q;
    for (int i = 3; i >= 0; i--) begin
      if (!busy_q[i]) free_tag = 2'(i);
    end
  end

  assign rsp_ok = (out_resp_in == 2'd1) ||
                  (out_resp_in == 2'd2);

  always_comb begin
    rsp_hit = 1'b0;
    rsp_bad = 1'b0;
    unique case (1'b1)
      (out_resp_in == 2'd3): rsp_bad = 1'b1;
      (rsp_ok && busy_q[out_tag_in]): rsp_hit = 1'b1;
      (rsp_ok && !busy_q[out_tag_in]): rsp_bad = 1'b1;
      default: ;
    endcase
  end

  // a response landing on the expiry cycle wins over the timeout
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      expire[i] = busy_q[i] &&
                  (tmr_q[i] == TMR_LAST) &&
                  !(rsp_hit && (out_tag_in == 2'(i)));
    end
  end

  always_comb begin
    state_d    = state_q;
    op_ready   = 1'b0;
    alloc      = 1'b0;
    b_d        = b_q;
    stag_d     = stag_q;
    req_cmd_d  = 4'd0;
    req_data_d = 32'd0;
    req_tag_d  = 2'd0;
    unique case (state_q)
      IDLE: begin
        op_ready = have_free && !reset;
        if (op_valid && op_ready &&
            (op_cmd != 4'd0)) begin
          alloc      = 1'b1;
          req_cmd_d  = op_cmd;
          req_data_d = op_a;
          req_tag_d  = free_tag;
          b_d        = op_b;
          stag_d     = free_tag;
          state_d    = SEND_B;
        end
      end
      SEND_B: begin
        req_data_d = b_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // timer of the tag in SEND_B is held at 0 so counting starts
  // with the operand2 beat on the bus
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < 4; i++) begin
      cmd_d[i] = cmd_q[i];
      tmr_d[i] = busy_q[i] ? tmr_q[i] + 8'd1 : 8'd0;
      if (state_q == SEND_B &&
          stag_q == 2'(i)) begin
        tmr_d[i] = 8'd0;
      end
      if (expire[i]) begin
        busy_d[i] = 1'b0;
        tmr_d[i]  = 8'd0;
      end
      if (rsp_hit && out_tag_in == 2'(i)) begin
        busy_d[i] = 1'b0;
        tmr_d[i]  = 8'd0;
      end
      if (alloc && free_tag == 2'(i)) begin
        busy_d[i] = 1'b1;
        cmd_d[i]  = op_cmd;
        tmr_d[i]  = 8'd0;
      end
    end
  end

  always_comb begin
    outst_d = 3'd0;
    for (int i = 0; i < 4; i++) begin
      outst_d = outst_d + {2'd0, busy_d[i]};
    end
  end

  always_comb begin
    res_valid_d = rsp_hit;
    res_cmd_d   = res_cmd_q;
    res_resp_d  = res_resp_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    if (rsp_hit) begin
      res_cmd_d  = cmd_q[out_tag_in];
      res_resp_d = out_resp_in;
      res_data_d = out_data_in;
      res_tag_d  = out_tag_in;
    end
    err_to_d = err_to_q | (|expire);
    err_un_d = rsp_bad;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 4'd0;
      b_q         <= 32'd0;
      stag_q      <= 2'd0;
      req_cmd_q   <= 4'd0;
      req_data_q  <= 32'd0;
      req_tag_q   <= 2'd0;
      res_valid_q <= 1'b0;
      res_cmd_q   <= 4'd0;
      res_resp_q  <= 2'd0;
      res_data_q  <= 32'd0;
      res_tag_q   <= 2'd0;
      outst_q     <= 3'd0;
      err_to_q    <= 1'b0;
      err_un_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cmd_q[i] <= 4'd0;
        tmr_q[i] <= 8'd0;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      b_q         <= b_d;
      stag_q      <= stag_d;
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      res_valid_q <= res_valid_d;
      res_cmd_q   <= res_cmd_d;
      res_resp_q  <= res_resp_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      outst_q     <= outst_d;
      err_to_q    <= err_to_d;
      err_un_q    <= err_un_d;
      for (int i = 0; i < 4; i++) begin
        cmd_q[i] <= cmd_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign req_cmd_out    = req_cmd_q;
  assign req_data_out   = req_data_q;
  assign req_tag_out    = req_tag_q;
  assign res_valid      = res_valid_q;
  assign res_cmd        = res_cmd_q;
  assign res_resp       = res_resp_q;
  assign res_data       = res_data_q;
  assign res_tag        = res_tag_q;
  assign outstanding    = outst_q;
  assign err_timeout    = err_to_q;
  assign err_unexpected = err_un_q;

endmodule

// File: tb/tb_calc2_port_requester.sv
// Self-checking bench for calc2_port_requester with a
// transaction-level tag/timeout model and random traffic.
module tb_calc2_port_requester;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op_cmd = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  out_resp_in = '0;
  logic [31:0] out_data_in = '0;
  logic [1:0]  out_tag_in = '0;
  logic        res_valid;
  logic [3:0]  res_cmd;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic [1:0]  res_tag;
  logic [2:0]  outstanding;
  logic        err_timeout;
  logic        err_unexpected;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  bit         mbusy [4];
  logic [3:0] mcmd [4];
  int         mexp [4];
  bit         mto;

  calc2_port_requester #(.TIMEOUT(TO)) dut (
    .c_clk(clk), .reset(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
    .req_cmd_out(req_cmd_out),
    .req_data_out(req_data_out),
    .req_tag_out(req_tag_out),
    .out_resp_in(out_resp_in),
    .out_data_in(out_data_in),
    .out_tag_in(out_tag_in),
    .res_valid(res_valid), .res_cmd(res_cmd),
    .res_resp(res_resp), .res_data(res_data),
    .res_tag(res_tag), .outstanding(outstanding),
    .err_timeout(err_timeout),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      mbusy[i] = 0;
      mcmd[i] = '0;
      mexp[i] = 0;
    end
    mto = 0;
  endfunction

  // a tag is lost once the current cycle reaches its deadline
  function automatic void expire_model();
    for (int i = 0; i < 4; i++) begin
      if (mbusy[i] && cyc >= mexp[i]) begin
        mbusy[i] = 0;
        mto = 1;
      end
    end
  endfunction

  function automatic int nbusy();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    model_clear();
    checks++;
    if ({op_ready, req_cmd_out, req_data_out, req_tag_out,
         res_valid, res_cmd, res_resp, res_data, res_tag,
         outstanding, err_timeout, err_unexpected} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got ready=%b cmd=%0h data=%0h out=%0d",
               op_ready, req_cmd_out, req_data_out, outstanding);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got %b exp 1", op_ready);
    end
  endtask

  task automatic issue(input logic [3:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bit rdy;
    int et;
    expire_model();
    rdy = nbusy() < 4;
    et = 0;
    for (int i = 3; i >= 0; i--) if (!mbusy[i]) et = i;
    op_valid = 1'b1;
    op_cmd = c;
    op_a = a;
    op_b = b;
    #1;
    checks++;
    if (op_ready !== rdy) begin
      errs++;
      $display("FAIL issue_ready got %b exp %b", op_ready, rdy);
    end
    step();
    op_valid = 1'b0;
    if (!rdy || c == 4'd0) begin
      expire_model();
      checks++;
      if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0 ||
          outstanding !== 3'(nbusy())) begin
        errs++;
        $display("FAIL issue_noop got cmd=%0h data=%0h out=%0d exp 0 0 %0d",
                 req_cmd_out, req_data_out, outstanding, nbusy());
      end
      return;
    end
    mbusy[et] = 1;
    mcmd[et] = c;
    mexp[et] = 1 << 30;
    expire_model();
    checks++;
    if (req_cmd_out !== c || req_data_out !== a ||
        req_tag_out !== 2'(et) || op_ready !== 1'b0 ||
        outstanding !== 3'(nbusy())) begin
      errs++;
      $display("FAIL issue_beat1 got cmd=%0h data=%0h tag=%0d rdy=%b out=%0d exp %0h %0h %0d 0 %0d",
               req_cmd_out, req_data_out, req_tag_out, op_ready,
               outstanding, c, a, et, nbusy());
    end
    step();
    mexp[et] = cyc + TO;
    expire_model();
    checks++;
    if (req_cmd_out !== 4'd0 || req_data_out !== b ||
        req_tag_out !== 2'd0 ||
        outstanding !== 3'(nbusy())) begin
      errs++;
      $display("FAIL issue_beat2 got cmd=%0h data=%0h tag=%0d out=%0d exp 0 %0h 0 %0d",
               req_cmd_out, req_data_out, req_tag_out, outstanding,
               b, nbusy());
    end
  endtask

  task automatic respond(input logic [1:0] r,
                         input logic [1:0] t,
                         input logic [31:0] d);
    bit hit;
    logic [3:0] ec;
    expire_model();
    hit = (r == 2'd1 || r == 2'd2) && mbusy[t];
    ec = mcmd[t];
    out_resp_in = r;
    out_tag_in = t;
    out_data_in = d;
    step();
    out_resp_in = 2'd0;
    if (hit) mbusy[t] = 0;
    expire_model();
    checks++;
    if (res_valid !== hit ||
        err_unexpected !== (!hit && r != 2'd0)) begin
      errs++;
      $display("FAIL resp_kind got vld=%b unexp=%b exp %b %b",
               res_valid, err_unexpected, hit, !hit && r != 0);
    end
    if (hit) begin
      checks++;
      if (res_cmd !== ec || res_resp !== r ||
          res_data !== d || res_tag !== t) begin
        errs++;
        $display("FAIL resp_fields got cmd=%0h resp=%0d data=%0h tag=%0d exp %0h %0d %0h %0d",
                 res_cmd, res_resp, res_data, res_tag, ec, r, d, t);
      end
    end
    checks++;
    if (outstanding !== 3'(nbusy()) ||
        err_timeout !== mto) begin
      errs++;
      $display("FAIL resp_state got out=%0d to=%b exp %0d %b",
               outstanding, err_timeout, nbusy(), mto);
    end
  endtask

  task automatic idle_check();
    step();
    expire_model();
    checks++;
    if (res_valid !== 1'b0 || err_unexpected !== 1'b0 ||
        req_cmd_out !== 4'd0 ||
        outstanding !== 3'(nbusy()) ||
        err_timeout !== mto) begin
      errs++;
      $display("FAIL idle got vld=%b unexp=%b cmd=%0h out=%0d to=%b exp 0 0 0 %0d %b",
               res_valid, err_unexpected, req_cmd_out, outstanding,
               err_timeout, nbusy(), mto);
    end
  endtask

  task automatic test_single_add();
    issue(4'd1, 32'd5, 32'd7);
    step();
    step();
    respond(2'd1, 2'd0, 32'd12);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd12 ||
        outstanding !== 3'd0) begin
      errs++;
      $display("FAIL add_result got vld=%b data=%0d out=%0d exp 1 12 0",
               res_valid, res_data, outstanding);
    end
    idle_check();
  endtask

  task automatic test_zero_cmd();
    issue(4'd0, 32'h11, 32'h22);
    issue(4'd2, 32'h30, 32'h10);
    checks++;
    if (outstanding !== 3'd1) begin
      errs++;
      $display("FAIL zero_cmd_count got %0d exp 1", outstanding);
    end
    respond(2'd1, 2'd0, 32'h20);
  endtask

  task automatic test_exhaust();
    for (int i = 0; i < 4; i++)
      issue(4'(i + 1), 32'(100 + i), 32'(200 + i));
    checks++;
    if (op_ready !== 1'b0 || outstanding !== 3'd4) begin
      errs++;
      $display("FAIL exhaust got rdy=%b out=%0d exp 0 4",
               op_ready, outstanding);
    end
    respond(2'd1, 2'd2, 32'hABC);
    checks++;
    if (op_ready !== 1'b1) begin
      errs++;
      $display("FAIL exhaust_free got rdy=%b exp 1", op_ready);
    end
    issue(4'd6, 32'h55, 32'h66);
  endtask

  task automatic test_out_of_order();
    issue(4'd1, 32'd1, 32'd2);
    issue(4'd2, 32'd9, 32'd3);
    issue(4'd5, 32'd4, 32'd1);
    respond(2'd1, 2'd2, 32'd8);
    respond(2'd2, 2'd0, 32'hFFFF_FFFF);
    respond(2'd1, 2'd1, 32'd6);
    idle_check();
  endtask

  task automatic test_unexpected();
    respond(2'd1, 2'd3, 32'd77);
    idle_check();
    issue(4'd6, 32'd8, 32'd2);
    respond(2'd3, 2'd0, 32'd0);
    checks++;
    if (outstanding !== 3'd1) begin
      errs++;
      $display("FAIL unexp_busy got out=%0d exp 1", outstanding);
    end
    idle_check();
    respond(2'd1, 2'd0, 32'd2);
  endtask

  task automatic test_timeout();
    issue(4'd1, 32'd3, 32'd4);
    for (int k = 1; k < TO; k++) begin
      step();
      checks++;
      if (outstanding !== 3'd1 || err_timeout !== 1'b0) begin
        errs++;
        $display("FAIL timeout_early k=%0d got out=%0d to=%b exp 1 0",
                 k, outstanding, err_timeout);
      end
    end
    step();
    expire_model();
    checks++;
    if (outstanding !== 3'd0 || err_timeout !== 1'b1 ||
        res_valid !== 1'b0) begin
      errs++;
      $display("FAIL timeout_fire got out=%0d to=%b vld=%b exp 0 1 0",
               outstanding, err_timeout, res_valid);
    end
    respond(2'd1, 2'd0, 32'd7);
    idle_check();
  endtask

  task automatic test_reset_midflight();
    issue(4'd1, 32'd1, 32'd1);
    issue(4'd2, 32'd2, 32'd2);
    op_valid = 1'b1;
    op_cmd = 4'd5;
    op_a = 32'hA;
    op_b = 32'hB;
    step();
    op_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if ({op_ready, req_cmd_out, req_data_out, req_tag_out,
         res_valid, res_cmd, res_resp, res_data, res_tag,
         outstanding, err_timeout, err_unexpected} !== '0) begin
      errs++;
      $display("FAIL midreset got cmd=%0h data=%0h out=%0d",
               req_cmd_out, req_data_out, outstanding);
    end
    rst = 1'b0;
    model_clear();
    step();
    issue(4'd2, 32'h40, 32'h41);
    respond(2'd1, 2'd0, 32'h1);
  endtask

  task automatic test_random();
    int sel;
    int t;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 5);
      if (sel <= 1) begin
        issue(4'($urandom_range(0, 15)), $urandom, $urandom);
      end else if (sel <= 3) begin
        t = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) if (mbusy[i]) t = i;
        respond(2'($urandom_range(1, 2)), 2'(t), $urandom);
      end else if (sel == 4) begin
        respond(2'($urandom_range(1, 3)),
                2'($urandom_range(0, 3)), $urandom);
      end else begin
        idle_check();
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_add();
    test_zero_cmd();
    test_reset();
    test_exhaust();
    test_reset();
    test_out_of_order();
    test_unexpected();
    test_timeout();
    test_reset();
    test_reset_midflight();
    test_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/calc2_port_requester.md
Name: calc2_port_requester

Overview:
- Hardware initiator for one calc2 request port. It is the other end of the req*_cmd_in/data_in/tag_in and out_resp/out_data/out_tag channels.
- Accepts operations from a local valid/ready source and serializes them onto the calc2 two-cycle request protocol (cmd + operand1, then operand2).
- Allocates one of four tags per request and matches returning responses by tag.
- Delivers tagged results upstream, flags timeouts and unexpected responses.

Parameters:
- TIMEOUT, 64: cycles after operand2 issue before an outstanding tag is declared lost (range 2..255).

Ports:
- c_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  upstream operation available.
- op_ready  out  1  block can accept an operation this cycle.
- op_cmd  in  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others passed through).
- op_a  in  32  operand1.
- op_b  in  32  operand2.
- req_cmd_out  out  4  to calc2 reqN_cmd_in.
- req_data_out  out  32  to calc2 reqN_data_in.
- req_tag_out  out  2  to calc2 reqN_tag_in.
- out_resp_in  in  2  from calc2 out_respN (0 none, 1 ok, 2 overflow/underflow/invalid, 3 unused).
- out_data_in  in  32  from calc2 out_dataN.
- out_tag_in  in  2  from calc2 out_tagN.
- res_valid  out  1  one-cycle result strobe.
- res_cmd  out  4  command originally issued under res_tag.
- res_resp  out  2  captured response code.
- res_data  out  32  captured result.
- res_tag  out  2  tag of result.
- outstanding  out  3  count of tags in flight (0..4).
- err_timeout  out  1  sticky; set on any timeout.
- err_unexpected  out  1  one-cycle pulse on response for a non-outstanding tag or resp=3.

Behaviour:
- Reset: all outputs 0.
  - req_cmd_out=0, req_data_out=0, req_tag_out=0, res_* = 0, outstanding=0, err_* = 0.
  - FSM=IDLE; all tags free; all timers 0.
  - A reset asserted mid-operation abandons in-flight tags with no result.
- FSM states: IDLE, SEND_B.
  - IDLE: op_ready = (free tag exists). On op_valid&&op_ready with op_cmd!=0:
    - Next cycle drive req_cmd_out=op_cmd, req_data_out=op_a, req_tag_out = lowest-numbered free tag.
    - Latch op_b and cmd; mark tag busy; go SEND_B.
  - op_cmd==0: the operation is consumed (handshake completes), no bus activity, no tag used, stay IDLE.
  - SEND_B: op_ready=0. Drive req_cmd_out=0, req_data_out=latched op_b, req_tag_out=0. Go IDLE.
  - Other cycles: req_cmd_out=0, req_data_out=0.
- Throughput: max one request per 2 cycles. Outputs are registered (1-cycle latency from accept to cmd on bus).
- Free-tag view: op_ready uses registered tag state. A tag freed by a response in cycle N is allocatable from cycle N+1.
- Response handling (every cycle, independent of FSM):
  - out_resp_in in {1,2} with busy tag: next cycle res_valid=1 carrying resp, data, tag and stored cmd; tag freed; its timer cleared.
  - out_resp_in in {1,2} with free tag, or out_resp_in==3: err_unexpected pulses next cycle, no res_valid, state unchanged.
  - out_resp_in==0: ignored.
- Timers: each busy tag's timer counts from the SEND_B cycle.
  - Reaching TIMEOUT with no response: tag freed, err_timeout set (sticky until reset), no res_valid.
  - A later response on that tag counts as unexpected.
  - Response arriving in the same cycle the timer would expire: the response wins, no timeout.
- outstanding: registered count of busy tags. Updated with simultaneous allocate and free: net 0 change.

Test Plan:
- Single add: op_cmd=1, a=5, b=7. Bus shows (cmd1, data5, tag0) then (cmd0, data7). Inject resp=1, data=12, tag0 3 cycles later. Expect res_valid one cycle later with cmd1, resp1, data12, tag0; outstanding returns 0.
- Tag exhaustion: issue 4 ops, no responses. Tags 0,1,2,3 are used in order; op_ready=0 and outstanding=4. Respond tag2 → op_ready=1 next cycle; next op reuses tag2.
- Out-of-order completion: tags 0..2 in flight; responses arrive tag2, tag0, tag1 (resp=2 on tag0). res_* follows the same order with the correct stored cmds.
- Unexpected response: no tags busy; inject resp=1 tag3 → err_unexpected pulses one cycle; res_valid stays 0. Also inject resp=3 on a busy tag → pulse, tag remains busy.
- Timeout: TIMEOUT=8, issue op, never respond. Tag freed and err_timeout=1 at cycle 8 after SEND_B; later resp on that tag → err_unexpected.
- Reset mid-flight: 3 tags busy, assert reset during SEND_B. All outputs 0 next cycle, outstanding=0, and next op uses tag0.
